// File: rtl/vx_ifetch_credit_arb.sv
// Credit-gated round-robin instruction-fetch arbiter with one registered grant slot.
// Optional macro IBUF_POP_BYPASS_EN lets a same-cycle ibuf_pop make a credit-starved warp eligible.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

module vx_ifetch_credit_arb #(
    parameter int unsigned NUM_WARPS = `NUM_WARPS,
    parameter int unsigned IBUF_SIZE = 2,
    localparam int unsigned WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WARPS-1:0] warp_valid,
    input  logic [NUM_WARPS-1:0] ibuf_pop,
    output logic                 fetch_valid,
    output logic [WW-1:0]        fetch_wid,
    input  logic                 fetch_ready,
    output logic [NUM_WARPS-1:0] ibuf_full,
    output logic                 credit_err
);

    localparam int unsigned CW = $clog2(IBUF_SIZE + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(IBUF_SIZE);

    logic [NUM_WARPS-1:0][CW-1:0] credit_q, credit_d;
    logic [WW-1:0]                rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]                fetch_wid_q, fetch_wid_d;
    logic                         fetch_valid_q, fetch_valid_d;
    logic                         credit_err_q, credit_err_d;

    logic [NUM_WARPS-1:0]         eligible;
    logic [NUM_WARPS-1:0]         dec;
    logic [WW-1:0]                grant;
    logic                         any_eligible;
    logic                         load;

    always_comb begin
        eligible = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
`ifdef IBUF_POP_BYPASS_EN
            eligible[w] = warp_valid[w] && ((credit_q[w] != '0) || ibuf_pop[w]);
`else
            eligible[w] = warp_valid[w] && (credit_q[w] != '0);
`endif
        end
    end

    // rr_ptr is always < NUM_WARPS, so a single conditional subtract wraps the scan index.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        grant        = '0;
        any_eligible = 1'b0;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_WARPS) begin
                idx = idx - NUM_WARPS;
            end
            if (!any_eligible && eligible[idx[WW-1:0]]) begin
                any_eligible = 1'b1;
                grant        = idx[WW-1:0];
            end
        end
    end

    assign load = !fetch_valid_q || fetch_ready;

    always_comb begin
        dec = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            dec[w] = load && any_eligible && (grant == WW'(w));
        end
    end

    always_comb begin
        fetch_valid_d = fetch_valid_q;
        fetch_wid_d   = fetch_wid_q;
        rr_ptr_d      = rr_ptr_q;
        credit_d      = credit_q;
        credit_err_d  = credit_err_q;

        if (load) begin
            fetch_valid_d = any_eligible;
            fetch_wid_d   = grant;
            if (any_eligible) begin
                rr_ptr_d = (grant == WW'(NUM_WARPS - 1)) ? '0 : grant + 1'b1;
            end
        end

        // A pop paired with a same-cycle grant nets to zero and can never overflow.
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            case ({dec[w], ibuf_pop[w]})
                2'b10: credit_d[w] = credit_q[w] - 1'b1;
                2'b01: begin
                    if (credit_q[w] == CREDIT_MAX) begin
                        credit_err_d = 1'b1;
                    end else begin
                        credit_d[w] = credit_q[w] + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_q      <= {NUM_WARPS{CREDIT_MAX}};
            rr_ptr_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_wid_q   <= '0;
            credit_err_q  <= 1'b0;
        end else begin
            credit_q      <= credit_d;
            rr_ptr_q      <= rr_ptr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_wid_q   <= fetch_wid_d;
            credit_err_q  <= credit_err_d;
        end
    end

    always_comb begin
        ibuf_full = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            ibuf_full[w] = (credit_q[w] == '0);
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_wid   = fetch_wid_q;
    assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_vx_ifetch_credit_arb.sv
// Directed bench for vx_ifetch_credit_arb with NUM_WARPS=4, IBUF_SIZE=2.
// Expectations for the pop-bypass scenario follow IBUF_POP_BYPASS_EN.
module tb_vx_ifetch_credit_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] warp_valid = '0;
    logic [3:0] ibuf_pop = '0;
    logic       fetch_ready = 1'b0;
    logic       fetch_valid;
    logic [1:0] fetch_wid;
    logic [3:0] ibuf_full;
    logic       credit_err;

    int tests_run = 0;
    int tests_failed = 0;

    vx_ifetch_credit_arb #(.NUM_WARPS(4), .IBUF_SIZE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .warp_valid (warp_valid),
        .ibuf_pop   (ibuf_pop),
        .fetch_valid(fetch_valid),
        .fetch_wid  (fetch_wid),
        .fetch_ready(fetch_ready),
        .ibuf_full  (ibuf_full),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        warp_valid = '0;
        ibuf_pop = '0;
        fetch_ready = 1'b0;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
        tests_run++;
        if (fetch_wid !== 2'd0) begin tests_failed++; $display("FAIL reset_wid: got %0d want 0", fetch_wid); end
        tests_run++;
        if (credit_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", credit_err); end
        tests_run++;
        if (ibuf_full !== 4'b0000) begin tests_failed++; $display("FAIL reset_full: got %b want 0000", ibuf_full); end
        for (int w = 0; w < 4; w++) begin
            tests_run++;
            if (dut.credit_q[w] !== 2'd2) begin tests_failed++; $display("FAIL reset_credit[%0d]: got %0d want 2", w, dut.credit_q[w]); end
        end
        tests_run++;
        if (dut.rr_ptr_q !== 2'd0) begin tests_failed++; $display("FAIL reset_rr: got %0d want 0", dut.rr_ptr_q); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_full;
        do_reset();
        warp_valid = 4'b1111;
        fetch_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_full = (i < 4) ? 4'b0000 : 4'((1 << (i - 3)) - 1);
            tests_run++;
            if (fetch_valid !== 1'b1 || fetch_wid !== 2'(i % 4)) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: got v=%b wid=%0d want v=1 wid=%0d", i, fetch_valid, fetch_wid, i % 4);
            end
            tests_run++;
            if (ibuf_full !== exp_full) begin tests_failed++; $display("FAIL rr_full[%0d]: got %b want %b", i, ibuf_full, exp_full); end
        end
        step();
        tests_run++;
        if (fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_drained_valid: got %b want 0", fetch_valid); end
        tests_run++;
        if (ibuf_full !== 4'b1111) begin tests_failed++; $display("FAIL rr_drained_full: got %b want 1111", ibuf_full); end
        tests_run++;
        if (dut.rr_ptr_q !== 2'd0) begin tests_failed++; $display("FAIL rr_ptr_idle: got %0d want 0", dut.rr_ptr_q); end
    endtask

    task automatic test_stall();
        do_reset();
        warp_valid = 4'b0100;
        fetch_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 1) warp_valid = 4'b0000;
            tests_run++;
            if (fetch_valid !== 1'b1 || fetch_wid !== 2'd2) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got v=%b wid=%0d want v=1 wid=2", k, fetch_valid, fetch_wid);
            end
            tests_run++;
            if (dut.credit_q[2] !== 2'd1) begin tests_failed++; $display("FAIL stall_credit[%0d]: got %0d want 1", k, dut.credit_q[2]); end
            tests_run++;
            if (dut.rr_ptr_q !== 2'd3) begin tests_failed++; $display("FAIL stall_rr[%0d]: got %0d want 3", k, dut.rr_ptr_q); end
        end
        fetch_ready = 1'b1;
        step();
        tests_run++;
        if (fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_release_valid: got %b want 0", fetch_valid); end
        tests_run++;
        if (dut.credit_q[2] !== 2'd1 || dut.rr_ptr_q !== 2'd3) begin
            tests_failed++;
            $display("FAIL stall_release_state: got credit=%0d rr=%0d want credit=1 rr=3", dut.credit_q[2], dut.rr_ptr_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_wid [4];
        exp_wid = '{2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        warp_valid = 4'b0101;
        fetch_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (fetch_valid !== 1'b1 || fetch_wid !== exp_wid[i]) begin
                tests_failed++;
                $display("FAIL b2b_grant[%0d]: got v=%b wid=%0d want v=1 wid=%0d", i, fetch_valid, fetch_wid, exp_wid[i]);
            end
        end
        step();
        tests_run++;
        if (fetch_valid !== 1'b0 || ibuf_full !== 4'b0101) begin
            tests_failed++;
            $display("FAIL b2b_end: got v=%b full=%b want v=0 full=0101", fetch_valid, ibuf_full);
        end
    endtask

    task automatic test_pop_bypass();
        do_reset();
        warp_valid = 4'b0010;
        fetch_ready = 1'b1;
        step();
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_wid !== 2'd1 || ibuf_full !== 4'b0010) begin
            tests_failed++;
            $display("FAIL byp_drain: got v=%b wid=%0d full=%b want v=1 wid=1 full=0010", fetch_valid, fetch_wid, ibuf_full);
        end
        step();
        tests_run++;
        if (fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL byp_starved: got v=%b want 0", fetch_valid); end
        ibuf_pop = 4'b0010;
        step();
        ibuf_pop = 4'b0000;
`ifdef IBUF_POP_BYPASS_EN
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_wid !== 2'd1) begin
            tests_failed++;
            $display("FAIL byp_same_cycle: got v=%b wid=%0d want v=1 wid=1", fetch_valid, fetch_wid);
        end
        tests_run++;
        if (dut.credit_q[1] !== 2'd0) begin tests_failed++; $display("FAIL byp_credit: got %0d want 0", dut.credit_q[1]); end
        step();
        tests_run++;
        if (fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL byp_after: got v=%b want 0", fetch_valid); end
`else
        tests_run++;
        if (fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL nobyp_same_cycle: got v=%b want 0", fetch_valid); end
        tests_run++;
        if (dut.credit_q[1] !== 2'd1) begin tests_failed++; $display("FAIL nobyp_credit: got %0d want 1", dut.credit_q[1]); end
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_wid !== 2'd1) begin
            tests_failed++;
            $display("FAIL nobyp_next_cycle: got v=%b wid=%0d want v=1 wid=1", fetch_valid, fetch_wid);
        end
`endif
    endtask

    task automatic test_credit_err();
        do_reset();
        ibuf_pop = 4'b0001;
        step();
        ibuf_pop = 4'b0000;
        tests_run++;
        if (dut.credit_q[0] !== 2'd2) begin tests_failed++; $display("FAIL err_credit_hold: got %0d want 2", dut.credit_q[0]); end
        tests_run++;
        if (credit_err !== 1'b1) begin tests_failed++; $display("FAIL err_set: got %b want 1", credit_err); end
        repeat (3) step();
        tests_run++;
        if (credit_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b want 1", credit_err); end
        do_reset();
        tests_run++;
        if (credit_err !== 1'b0) begin tests_failed++; $display("FAIL err_cleared: got %b want 0", credit_err); end
    endtask

    task automatic test_pop_with_grant();
        do_reset();
        warp_valid = 4'b0001;
        fetch_ready = 1'b1;
        ibuf_pop = 4'b0001;
        step();
        ibuf_pop = 4'b0000;
        warp_valid = 4'b0000;
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_wid !== 2'd0) begin
            tests_failed++;
            $display("FAIL popgrant_grant: got v=%b wid=%0d want v=1 wid=0", fetch_valid, fetch_wid);
        end
        tests_run++;
        if (dut.credit_q[0] !== 2'd2 || credit_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL popgrant_credit: got credit=%0d err=%b want credit=2 err=0", dut.credit_q[0], credit_err);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        warp_valid = 4'b1000;
        fetch_ready = 1'b0;
        step();
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_wid !== 2'd3 || dut.credit_q[3] !== 2'd1) begin
            tests_failed++;
            $display("FAIL midrst_pre: got v=%b wid=%0d credit=%0d want v=1 wid=3 credit=1", fetch_valid, fetch_wid, dut.credit_q[3]);
        end
        #3 reset = 1'b1;
        #1;
        tests_run++;
        if (fetch_valid !== 1'b0 || fetch_wid !== 2'd0) begin
            tests_failed++;
            $display("FAIL midrst_out: got v=%b wid=%0d want v=0 wid=0", fetch_valid, fetch_wid);
        end
        tests_run++;
        if (dut.credit_q !== {4{2'd2}} || dut.rr_ptr_q !== 2'd0) begin
            tests_failed++;
            $display("FAIL midrst_state: got credits=%h rr=%0d want credits=aa rr=0", dut.credit_q, dut.rr_ptr_q);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        tests_run++;
        if (fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_release: got v=%b want 0", fetch_valid); end
        step();
        tests_run++;
        if (fetch_valid !== 1'b1 || fetch_wid !== 2'd3 || dut.credit_q[3] !== 2'd1) begin
            tests_failed++;
            $display("FAIL midrst_regrant: got v=%b wid=%0d credit=%0d want v=1 wid=3 credit=1", fetch_valid, fetch_wid, dut.credit_q[3]);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_back_to_back();
        test_pop_bypass();
        test_credit_err();
        test_pop_with_grant();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
